// File: rtl/output_mem_sched.sv
// Cycle scheduler for the dual-port output SRAM wrapper: grants PE partial-sum reads,
// tracks them until CIM writeback, and sequences the wrapper's run/drain/scan phases.
module output_mem_sched #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned PEND   = 4,
  localparam int unsigned CNT_W = $clog2(PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              scan_in_start,
  input  logic              scan_out_start,
  input  logic              pe1_req_valid,
  input  logic              pe2_req_valid,
  input  logic [ADDR_W-1:0] pe1_req_addr,
  input  logic [ADDR_W-1:0] pe2_req_addr,
  output logic              pe1_req_ready,
  output logic              pe2_req_ready,
  input  logic              wb1_valid,
  input  logic              wb2_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [ADDR_W-1:0] wb2_addr,
  output logic              rd1_valid,
  output logic              rd2_valid,
  output logic [ADDR_W-1:0] rd1_addr,
  output logic [ADDR_W-1:0] rd2_addr,
  output logic [1:0]        mem_scan_mode,
  output logic [ADDR_W-1:0] mem_scan_addr,
  output logic              scan_in_req,
  output logic              scan_out_valid,
  output logic              scan_done,
  output logic [CNT_W-1:0]  pend_count,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StScanIn, StScanOut} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        scan_addr_q, scan_addr_d;
  logic                     scan_done_q, scan_done_d;
  logic                     tog_q, tog_d;
  logic                     err_q, err_d;
  logic [PEND-1:0]          sb_valid_q, sb_valid_d;
  logic [PEND-1:0][ADDR_W-1:0] sb_addr_q, sb_addr_d;
  logic                     rd1_valid_q, rd2_valid_q;
  logic [ADDR_W-1:0]        rd1_addr_q, rd2_addr_q;

  logic [CNT_W-1:0]         occ;
  logic                     hit1, hit2;
  logic [PEND-1:0]          wb1_hit, wb2_hit;
  logic                     free1, free2, elig1, elig2, grant1, grant2, tie;
  logic                     wb_same, need1, need2;

  // Hazard lookup and occupancy are taken from the registered scoreboard only.
  always_comb begin
    occ     = '0;
    hit1    = 1'b0;
    hit2    = 1'b0;
    wb1_hit = '0;
    wb2_hit = '0;
    for (int i = 0; i < int'(PEND); i++) begin
      if (sb_valid_q[i]) begin
        occ = occ + CNT_W'(1);
        if (sb_addr_q[i] == pe1_req_addr) hit1 = 1'b1;
        if (sb_addr_q[i] == pe2_req_addr) hit2 = 1'b1;
        wb1_hit[i] = wb1_valid && (sb_addr_q[i] == wb1_addr);
        wb2_hit[i] = wb2_valid && (sb_addr_q[i] == wb2_addr);
      end
    end
  end

  always_comb begin
    free1  = int'(occ) < int'(PEND);
    free2  = int'(occ) <= int'(PEND) - 2;
    elig1  = (state_q == StRun) && pe1_req_valid && !hit1 && free1;
    elig2  = (state_q == StRun) && pe2_req_valid && !hit2 && free1;
    grant1 = elig1;
    grant2 = elig2;
    tie    = 1'b0;
    if (elig1 && elig2) begin
      if (pe1_req_addr == pe2_req_addr) begin
        tie    = 1'b1;
        grant1 = !tog_q;
        grant2 = tog_q;
      end else if (!free2) begin
        grant2 = 1'b0;
      end
    end
    tog_d = tog_q ^ tie;
  end

  // Frees and allocations touch disjoint entries, so they simply net out.
  always_comb begin
    wb_same    = wb1_valid && wb2_valid && (wb1_addr == wb2_addr);
    err_d      = err_q | wb_same | (wb1_valid && !(|wb1_hit)) | (wb2_valid && !(|wb2_hit));
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    if (!wb_same) sb_valid_d = sb_valid_q & ~(wb1_hit | wb2_hit);
    need1 = grant1;
    need2 = grant2;
    for (int i = 0; i < int'(PEND); i++) begin
      if (!sb_valid_q[i]) begin
        if (need1) begin
          sb_valid_d[i] = 1'b1;
          sb_addr_d[i]  = pe1_req_addr;
          need1         = 1'b0;
        end else if (need2) begin
          sb_valid_d[i] = 1'b1;
          sb_addr_d[i]  = pe2_req_addr;
          need2         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    scan_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        scan_addr_d = '0;
        if (run_en)              state_d = StRun;
        else if (scan_in_start)  state_d = StScanIn;
        else if (scan_out_start) state_d = StScanOut;
      end
      StRun:   if (!run_en) state_d = StDrain;
      StDrain: if (occ == '0) state_d = StIdle;
      StScanIn, StScanOut: begin
        if (scan_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = StIdle;
          scan_addr_d = '0;
          scan_done_d = 1'b1;
        end else begin
          scan_addr_d = scan_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      scan_addr_q <= '0;
      scan_done_q <= 1'b0;
      tog_q       <= 1'b0;
      err_q       <= 1'b0;
      sb_valid_q  <= '0;
      sb_addr_q   <= '0;
      rd1_valid_q <= 1'b0;
      rd2_valid_q <= 1'b0;
      rd1_addr_q  <= '0;
      rd2_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      scan_done_q <= scan_done_d;
      tog_q       <= tog_d;
      err_q       <= err_d;
      sb_valid_q  <= sb_valid_d;
      sb_addr_q   <= sb_addr_d;
      rd1_valid_q <= grant1;
      rd2_valid_q <= grant2;
      if (grant1) rd1_addr_q <= pe1_req_addr;
      if (grant2) rd2_addr_q <= pe2_req_addr;
    end
  end

  always_comb begin
    case (state_q)
      StScanIn:       mem_scan_mode = 2'b00;
      StRun, StDrain: mem_scan_mode = 2'b01;
      default:        mem_scan_mode = 2'b11;
    endcase
  end

  assign pe1_req_ready  = grant1;
  assign pe2_req_ready  = grant2;
  assign rd1_valid      = rd1_valid_q;
  assign rd2_valid      = rd2_valid_q;
  assign rd1_addr       = rd1_addr_q;
  assign rd2_addr       = rd2_addr_q;
  assign mem_scan_addr  = scan_addr_q;
  assign scan_in_req    = (state_q == StScanIn);
  assign scan_out_valid = (state_q == StScanOut);
  assign scan_done      = scan_done_q;
  assign pend_count     = occ;
  assign err            = err_q;

endmodule

// File: tb/tb_output_mem_sched.sv
// Directed bench for output_mem_sched; expected read grants are queued per lane
// when driven and checked against rd*_valid/rd*_addr on the following cycle.
module tb_output_mem_sched;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned PEND   = 4;
  localparam int unsigned CNT_W  = $clog2(PEND + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0, scan_in_start = 1'b0, scan_out_start = 1'b0;
  logic pe1_req_valid = 1'b0, pe2_req_valid = 1'b0;
  logic [ADDR_W-1:0] pe1_req_addr = '0, pe2_req_addr = '0;
  logic pe1_req_ready, pe2_req_ready;
  logic wb1_valid = 1'b0, wb2_valid = 1'b0;
  logic [ADDR_W-1:0] wb1_addr = '0, wb2_addr = '0;
  logic rd1_valid, rd2_valid;
  logic [ADDR_W-1:0] rd1_addr, rd2_addr;
  logic [1:0] mem_scan_mode;
  logic [ADDR_W-1:0] mem_scan_addr;
  logic scan_in_req, scan_out_valid, scan_done;
  logic [CNT_W-1:0] pend_count;
  logic err;

  int n_assert = 0;
  int n_fail   = 0;
  int q1[$];
  int q2[$];

  output_mem_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PEND(PEND)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .scan_in_start(scan_in_start), .scan_out_start(scan_out_start),
    .pe1_req_valid(pe1_req_valid), .pe2_req_valid(pe2_req_valid),
    .pe1_req_addr(pe1_req_addr), .pe2_req_addr(pe2_req_addr),
    .pe1_req_ready(pe1_req_ready), .pe2_req_ready(pe2_req_ready),
    .wb1_valid(wb1_valid), .wb2_valid(wb2_valid),
    .wb1_addr(wb1_addr), .wb2_addr(wb2_addr),
    .rd1_valid(rd1_valid), .rd2_valid(rd2_valid),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .mem_scan_mode(mem_scan_mode), .mem_scan_addr(mem_scan_addr),
    .scan_in_req(scan_in_req), .scan_out_valid(scan_out_valid),
    .scan_done(scan_done), .pend_count(pend_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after an edge; combinational readies settle 1ns later.
  task automatic drive(input logic v1, input int a1, input logic v2, input int a2,
                       input logic w1, input int b1, input logic w2, input int b2);
    pe1_req_valid = v1; pe1_req_addr = ADDR_W'(a1);
    pe2_req_valid = v2; pe2_req_addr = ADDR_W'(a2);
    wb1_valid = w1; wb1_addr = ADDR_W'(b1);
    wb2_valid = w2; wb2_addr = ADDR_W'(b2);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_grant(input logic e1, input logic e2);
    chk("pe1_ready", pe1_req_ready, e1);
    chk("pe2_ready", pe2_req_ready, e2);
    if (e1) q1.push_back(int'(pe1_req_addr));
    if (e2) q2.push_back(int'(pe2_req_addr));
  endtask

  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("rd1_valid", rd1_valid, 1);
      chk("rd1_addr", rd1_addr, e);
    end else chk("rd1_idle", rd1_valid, 0);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("rd2_valid", rd2_valid, 1);
      chk("rd2_addr", rd2_addr, e);
    end else chk("rd2_idle", rd2_valid, 0);
  endtask

  initial begin
    // Reset state, with a request held to confirm readies stay low
    #2;
    drive(1, 5, 1, 9, 0, 0, 0, 0);
    chk("rst_mode", mem_scan_mode, 2'b11);
    chk("rst_saddr", mem_scan_addr, 0);
    chk("rst_rd1v", rd1_valid, 0);
    chk("rst_rd2v", rd2_valid, 0);
    chk("rst_rd1a", rd1_addr, 0);
    chk("rst_rd2a", rd2_addr, 0);
    chk("rst_rdy1", pe1_req_ready, 0);
    chk("rst_rdy2", pe2_req_ready, 0);
    chk("rst_sin", scan_in_req, 0);
    chk("rst_sout", scan_out_valid, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_pend", pend_count, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_in();

    // Enter RUN
    run_en = 1'b1;
    tick();
    chk("run_mode", mem_scan_mode, 2'b01);

    // Two distinct addresses in one cycle: both granted
    drive(1, 5, 1, 9, 0, 0, 0, 0); exp_grant(1, 1); tick();
    chk("pend_2", pend_count, 2);

    // RAW hazard on 5: stalled until the cycle after wb1 of 5
    drive(1, 5, 0, 0, 0, 0, 0, 0); exp_grant(0, 0); tick();
    drive(1, 5, 0, 0, 1, 5, 0, 0); exp_grant(0, 0); tick();
    chk("pend_wb", pend_count, 1);
    drive(1, 5, 0, 0, 0, 0, 0, 0); exp_grant(1, 0); tick();
    chk("pend_regrant", pend_count, 2);
    drive(0, 0, 0, 0, 1, 5, 1, 9); exp_grant(0, 0); tick();
    chk("pend_clear", pend_count, 0);
    chk("err_clean", err, 0);

    // Same-address tie alternates lane1, lane2, lane1
    drive(1, 3, 1, 3, 0, 0, 0, 0); exp_grant(1, 0); tick();
    drive(1, 3, 1, 3, 1, 3, 0, 0); exp_grant(0, 0); tick();
    drive(1, 3, 1, 3, 0, 0, 0, 0); exp_grant(0, 1); tick();
    drive(1, 3, 1, 3, 0, 0, 1, 3); exp_grant(0, 0); tick();
    drive(1, 3, 1, 3, 0, 0, 0, 0); exp_grant(1, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 0, 0); exp_grant(0, 0); tick();
    chk("pend_tie_clear", pend_count, 0);

    // Fill all four entries, then one freed entry goes to lane 1 only
    drive(1, 10, 1, 11, 0, 0, 0, 0); exp_grant(1, 1); tick();
    drive(1, 12, 1, 13, 0, 0, 0, 0); exp_grant(1, 1); tick();
    chk("pend_full", pend_count, 4);
    drive(1, 14, 1, 15, 0, 0, 0, 0); exp_grant(0, 0); tick();
    drive(1, 14, 1, 15, 1, 10, 0, 0); exp_grant(0, 0); tick();
    chk("pend_one_free", pend_count, 3);
    drive(1, 14, 1, 15, 0, 0, 0, 0); exp_grant(1, 0); tick();
    chk("pend_refull", pend_count, 4);
    drive(0, 0, 1, 15, 0, 0, 0, 0); exp_grant(0, 0); tick();
    drive(0, 0, 0, 0, 1, 11, 1, 12); exp_grant(0, 0); tick();
    chk("pend_two_left", pend_count, 2);

    // Drain with two outstanding, then back to IDLE
    run_en = 1'b0;
    idle_in(); tick();
    chk("drain_mode", mem_scan_mode, 2'b01);
    drive(1, 20, 0, 0, 1, 13, 0, 0); exp_grant(0, 0); tick();
    chk("drain_pend1", pend_count, 1);
    chk("drain_stay", mem_scan_mode, 2'b01);
    drive(0, 0, 0, 0, 0, 0, 1, 14); tick();
    chk("drain_pend0", pend_count, 0);
    idle_in(); tick();
    chk("idle_mode", mem_scan_mode, 2'b11);
    chk("idle_err", err, 0);

    // Scan-out sweep of DEPTH words
    scan_out_start = 1'b1; tick(); scan_out_start = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("sout_valid", scan_out_valid, 1);
      chk("sout_addr", mem_scan_addr, i);
      chk("sout_mode", mem_scan_mode, 2'b11);
      chk("sout_done_lo", scan_done, 0);
      tick();
    end
    chk("sout_done", scan_done, 1);
    chk("sout_end", scan_out_valid, 0);
    tick();
    chk("sout_done_pulse", scan_done, 0);

    // Stray writeback sets sticky err
    drive(0, 0, 0, 0, 0, 0, 1, 7); tick();
    idle_in();
    chk("err_set", err, 1);
    tick(); tick();
    chk("err_sticky", err, 1);

    // Scan-in, then asynchronous reset mid-sweep
    scan_in_start = 1'b1; tick(); scan_in_start = 1'b0;
    chk("sin_mode", mem_scan_mode, 2'b00);
    chk("sin_req", scan_in_req, 1);
    chk("sin_addr0", mem_scan_addr, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("sin_addr5", mem_scan_addr, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", mem_scan_mode, 2'b11);
    chk("arst_addr", mem_scan_addr, 0);
    chk("arst_err", err, 0);
    chk("arst_req", scan_in_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 0, 0); tick();
    idle_in();
    chk("err_after_rst", err, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
